dat_transfer_ctrl: RTL and testbench

//  Sequences block transfers through the DAT-line physical layer (DAT PHY) of the SD host.
//  - Accepts one transfer request: direction, block count, block size, timeout.
//  - Per block: waits on the FIFO, pulses newService to the PHY, then waits for block completion.
//  - Counts blocks, runs the data timeout, checks the write CRC status, and reports done/error.
//  - Sits between the host register file and the DAT PHY, on the system clock domain.

---
 rtl/sd_dat_pkg.sv | 23 ++
 rtl/dat_timeout_cnt.sv | 35 +++
 rtl/dat_transfer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dat_transfer_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_pkg.sv
// Shared types and widths for the SD host DAT-line transfer controller.
package sd_dat_pkg;

   localparam int CNT_W = 16;
   localparam int TO_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FIFO,
      ST_ISSUE,
      ST_RUN,
      ST_FINISH,
      ST_FAIL
   } dat_ctrl_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_CRC     = 2'b10,
      ERR_ABORT   = 2'b11
   } dat_err_t;

endpackage

// File: rtl/dat_timeout_cnt.sv
// Per-block data timeout: loadable down-counter that holds at zero.
module dat_timeout_cnt
   import sd_dat_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            enable,
   input  logic [TO_W-1:0] load_value,
   output logic            expired
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_value;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - TO_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/dat_transfer_ctrl.sv
// Block-transfer sequencer between the host register file and the DAT PHY.
//
// state     | meaning
// IDLE      | waiting for start; config latched on start
// WAIT_FIFO | waiting for FIFO room (read) or data (write)
// ISSUE     | new_service pulse; timeout counter loaded
// RUN       | block in flight; timeout running
// FINISH    | done pulse, success
// FAIL      | done pulse, error set and held
module dat_transfer_ctrl
   import sd_dat_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             write_read,
   input  logic             multiblock,
   input  logic [CNT_W-1:0] block_count,
   input  logic [3:0]       block_size,
   input  logic             timeout_enable,
   input  logic [TO_W-1:0]  timeout_value,
   input  logic             abort,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   input  logic             phy_done,
   input  logic             phy_crc_ok,
   output logic             new_service,
   output logic             phy_write_read,
   output logic             phy_multiblock,
   output logic [3:0]       phy_block_size,
   output logic             phy_timeout_en,
   output logic [TO_W-1:0]  phy_timeout,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       error_code,
   output logic [CNT_W-1:0] blocks_done
);

   dat_ctrl_state_t  state_q, state_d;
   dat_err_t         error_code_q, error_code_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] blocks_done_q, blocks_done_d;
   logic [CNT_W-1:0] rem_init;
   logic [TO_W-1:0]  phy_timeout_q, phy_timeout_d;
   logic [3:0]       phy_block_size_q, phy_block_size_d;
   logic             phy_write_read_q, phy_write_read_d;
   logic             phy_multiblock_q, phy_multiblock_d;
   logic             phy_timeout_en_q, phy_timeout_en_d;
   logic             new_service_q, new_service_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             to_load, to_enable, to_expired;

   dat_timeout_cnt u_timeout (
      .clock      (clock),
      .reset      (reset),
      .load       (to_load),
      .enable     (to_enable),
      .load_value (phy_timeout_q),
      .expired    (to_expired)
   );

   assign rem_init = multiblock ? block_count : CNT_W'(1);

   always_comb begin
      state_d          = state_q;
      error_code_d     = error_code_q;
      remaining_d      = remaining_q;
      blocks_done_d    = blocks_done_q;
      phy_timeout_d    = phy_timeout_q;
      phy_block_size_d = phy_block_size_q;
      phy_write_read_d = phy_write_read_q;
      phy_multiblock_d = phy_multiblock_q;
      phy_timeout_en_d = phy_timeout_en_q;
      error_d          = error_q;
      to_load          = 1'b0;
      to_enable        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               phy_write_read_d = write_read;
               phy_multiblock_d = multiblock;
               phy_block_size_d = block_size;
               phy_timeout_en_d = timeout_enable;
               phy_timeout_d    = timeout_value;
               error_d          = 1'b0;
               error_code_d     = ERR_NONE;
               blocks_done_d    = '0;
               remaining_d      = rem_init;
               state_d          = (rem_init == '0) ? ST_FINISH : ST_WAIT_FIFO;
            end
         end
         ST_WAIT_FIFO: begin
            if (abort) begin
               error_code_d = ERR_ABORT;
               state_d      = ST_FAIL;
            end else if (!(phy_write_read_q ? fifo_empty : fifo_full)) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            to_load = 1'b1;
            if (abort) begin
               error_code_d = ERR_ABORT;
               state_d      = ST_FAIL;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            to_enable = phy_timeout_en_q;
            if (abort) begin
               error_code_d = ERR_ABORT;
               state_d      = ST_FAIL;
            end else if (phy_done) begin
               if (phy_write_read_q && !phy_crc_ok) begin
                  error_code_d = ERR_CRC;
                  state_d      = ST_FAIL;
               end else begin
                  if (blocks_done_q != '1) blocks_done_d = blocks_done_q + CNT_W'(1);
                  if (remaining_q != '0)   remaining_d   = remaining_q - CNT_W'(1);
                  state_d = (remaining_q <= CNT_W'(1)) ? ST_FINISH : ST_WAIT_FIFO;
               end
            end else if (phy_timeout_en_q && to_expired) begin
               error_code_d = ERR_TIMEOUT;
               state_d      = ST_FAIL;
            end
         end
         // Terminal states ignore abort so a transfer reports exactly one done.
         ST_FINISH: state_d = ST_IDLE;
         ST_FAIL:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (state_d == ST_FAIL) error_d = 1'b1;
      new_service_d = (state_d == ST_ISSUE);
      done_d        = (state_d == ST_FINISH) || (state_d == ST_FAIL);
      busy_d        = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         error_code_q     <= ERR_NONE;
         remaining_q      <= '0;
         blocks_done_q    <= '0;
         phy_timeout_q    <= '0;
         phy_block_size_q <= '0;
         phy_write_read_q <= 1'b0;
         phy_multiblock_q <= 1'b0;
         phy_timeout_en_q <= 1'b0;
         new_service_q    <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         error_code_q     <= error_code_d;
         remaining_q      <= remaining_d;
         blocks_done_q    <= blocks_done_d;
         phy_timeout_q    <= phy_timeout_d;
         phy_block_size_q <= phy_block_size_d;
         phy_write_read_q <= phy_write_read_d;
         phy_multiblock_q <= phy_multiblock_d;
         phy_timeout_en_q <= phy_timeout_en_d;
         new_service_q    <= new_service_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         error_q          <= error_d;
      end
   end

   assign new_service    = new_service_q;
   assign phy_write_read = phy_write_read_q;
   assign phy_multiblock = phy_multiblock_q;
   assign phy_block_size = phy_block_size_q;
   assign phy_timeout_en = phy_timeout_en_q;
   assign phy_timeout    = phy_timeout_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign error_code     = error_code_q;
   assign blocks_done    = blocks_done_q;

endmodule

// File: tb/tb_dat_transfer_ctrl.sv
// Directed self-checking bench for dat_transfer_ctrl.
module tb_dat_transfer_ctrl;
   import sd_dat_pkg::*;

   logic             clock = 1'b0;
   logic             reset;
   logic             start, write_read, multiblock;
   logic [CNT_W-1:0] block_count;
   logic [3:0]       block_size;
   logic             timeout_enable;
   logic [TO_W-1:0]  timeout_value;
   logic             abort, fifo_full, fifo_empty, phy_done, phy_crc_ok;
   logic             new_service, phy_write_read, phy_multiblock, phy_timeout_en;
   logic [3:0]       phy_block_size;
   logic [TO_W-1:0]  phy_timeout;
   logic             busy, done, error;
   logic [1:0]       error_code;
   logic [CNT_W-1:0] blocks_done;

   int n_vec = 0;
   int n_err = 0;
   int ns_cnt = 0;
   int done_cnt = 0;

   dat_transfer_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .write_read     (write_read),
      .multiblock     (multiblock),
      .block_count    (block_count),
      .block_size     (block_size),
      .timeout_enable (timeout_enable),
      .timeout_value  (timeout_value),
      .abort          (abort),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .phy_done       (phy_done),
      .phy_crc_ok     (phy_crc_ok),
      .new_service    (new_service),
      .phy_write_read (phy_write_read),
      .phy_multiblock (phy_multiblock),
      .phy_block_size (phy_block_size),
      .phy_timeout_en (phy_timeout_en),
      .phy_timeout    (phy_timeout),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .error_code     (error_code),
      .blocks_done    (blocks_done)
   );

   always #5 clock = ~clock;

   // After each call the bench sits 1 ns past a rising edge: outputs show the
   // current cycle and inputs set now are sampled at the next edge.
   task automatic tick();
      @(posedge clock);
      #1;
      if (new_service === 1'b1) ns_cnt++;
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 0; write_read = 0; multiblock = 0; block_count = '0;
      block_size = '0; timeout_enable = 0; timeout_value = '0; abort = 0;
      fifo_full = 0; fifo_empty = 0; phy_done = 0; phy_crc_ok = 0;
      ticks(3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", {error, error_code}, 0);
      chk("rst_bd", blocks_done, 0);
      chk("rst_ns", new_service, 0);
      chk("rst_cfg", {phy_write_read, phy_multiblock, phy_block_size, phy_timeout_en, phy_timeout}, 0);
      reset = 1'b0;
      tick();

      // abort while idle does nothing
      abort = 1'b1; tick(); abort = 1'b0; tick();
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_err", error, 0);

      // single write; multiblock=0 forces one block despite block_count 5
      write_read = 1; multiblock = 0; block_count = 5; block_size = 4'h9;
      timeout_enable = 0; timeout_value = 16'h1234; fifo_empty = 0;
      ns_cnt = 0; done_cnt = 0;
      go();                                   // WAIT_FIFO
      chk("sw_busy", busy, 1);
      chk("sw_cfg", {phy_write_read, phy_multiblock, phy_block_size, phy_timeout}, {1'b1, 1'b0, 4'h9, 16'h1234});
      chk("sw_ns_early", new_service, 0);
      tick();                                 // ISSUE: start cycle + 2
      chk("sw_ns", new_service, 1);
      ticks(5);                               // RUN, 5 cycles after new_service
      chk("sw_ns_pulse", new_service, 0);
      phy_done = 1; phy_crc_ok = 1;
      tick();                                 // FINISH
      phy_done = 0;
      chk("sw_done", done, 1);
      chk("sw_bd", blocks_done, 1);
      chk("sw_err", error, 0);
      tick();                                 // IDLE
      chk("sw_idle", {busy, done}, 0);
      chk("sw_cnt", {ns_cnt[15:0], done_cnt[15:0]}, {16'd1, 16'd1});

      // multi read, 3 blocks, fifo_full stalls block 2 by 4 cycles; crc ignored on reads
      write_read = 0; multiblock = 1; block_count = 3; block_size = 4'h2; fifo_full = 0;
      ns_cnt = 0; done_cnt = 0;
      go(); tick();                           // ISSUE block 1
      chk("mr_ns1", new_service, 1);
      tick();                                 // RUN
      phy_done = 1; phy_crc_ok = 0; fifo_full = 1;
      tick();                                 // WAIT_FIFO, first stalled cycle
      phy_done = 0;
      chk("mr_bd1", blocks_done, 1);
      chk("mr_busy", busy, 1);
      ticks(3);                               // 4th stalled cycle
      chk("mr_stall", new_service, 0);
      fifo_full = 0;
      tick();                                 // ISSUE block 2
      chk("mr_ns2", new_service, 1);
      tick();
      phy_done = 1; tick(); phy_done = 0;     // WAIT_FIFO
      chk("mr_bd2", blocks_done, 2);
      tick();                                 // ISSUE block 3
      chk("mr_ns3", new_service, 1);
      tick();
      phy_done = 1; tick(); phy_done = 0;     // FINISH
      chk("mr_done", {done, error}, 2'b10);
      chk("mr_bd3", blocks_done, 3);
      tick();
      chk("mr_cnt", {ns_cnt[15:0], done_cnt[15:0]}, {16'd3, 16'd1});

      // timeout 10: RUN entered at R, counter hits 0 at R+10, FAIL at R+11
      write_read = 1; multiblock = 0; timeout_enable = 1; timeout_value = 16'd10;
      go(); tick(); tick();                   // RUN, cycle R
      chk("to_en", phy_timeout_en, 1);
      ticks(10);                              // R+10, still running
      chk("to_not_yet", {done, error}, 0);
      tick();                                 // FAIL
      chk("to_done", {done, error}, 2'b11);
      chk("to_code", error_code, 2'b01);
      chk("to_bd", blocks_done, 0);
      tick();
      chk("to_held", {busy, done, error, error_code}, 5'b00101);

      // timeout 0 with phy_done in the first RUN cycle: phy_done wins
      timeout_value = 16'd0; phy_crc_ok = 1;
      go();
      chk("to0_err_clr", {error, error_code}, 0);
      tick(); tick();
      phy_done = 1; tick(); phy_done = 0;
      chk("to0_win", {done, error, blocks_done}, {1'b1, 1'b0, 16'd1});
      tick();
      // timeout 0 without phy_done: fails after the first RUN cycle
      go(); tick(); tick(); tick();
      chk("to0_fail", {done, error, error_code}, 4'b1101);
      tick();

      // crc fail on block 1 of 2
      timeout_enable = 0; multiblock = 1; block_count = 2; ns_cnt = 0;
      go(); tick(); tick();
      phy_done = 1; phy_crc_ok = 0; tick(); phy_done = 0; phy_crc_ok = 1;
      chk("crc_code", {done, error, error_code}, 4'b1110);
      chk("crc_bd", blocks_done, 0);
      ticks(4);
      chk("crc_ns", ns_cnt, 1);

      // abort during block 2 of 4 with phy_done in the same cycle
      block_count = 4;
      go(); tick(); tick();
      phy_done = 1; tick(); phy_done = 0;     // WAIT_FIFO
      tick(); tick();                         // RUN block 2
      abort = 1; phy_done = 1; tick(); abort = 0; phy_done = 0;
      chk("ab_code", {done, error, error_code}, 4'b1111);
      chk("ab_bd", blocks_done, 1);
      tick();

      // block_count 0: FINISH right after start, no new_service, error cleared
      block_count = 0; ns_cnt = 0;
      go();
      chk("z_done", {busy, done, error, error_code}, 5'b11000);
      tick();
      chk("z_idle", {busy, done}, 0);
      chk("z_ns", ns_cnt, 0);

      // start while busy is ignored
      multiblock = 0; write_read = 1; block_size = 4'hA; fifo_empty = 1;
      go();                                   // stalled in WAIT_FIFO
      write_read = 0; block_size = 4'h5; multiblock = 1;
      go();
      chk("sb_cfg", {phy_write_read, phy_multiblock, phy_block_size}, {1'b1, 1'b0, 4'hA});
      chk("sb_state", {busy, new_service}, 2'b10);
      fifo_empty = 0;
      tick();
      chk("sb_ns", new_service, 1);
      tick();                                 // RUN

      // async reset in RUN: outputs clear before any clock edge
      #2 reset = 1'b1;
      #1;
      chk("ar_out", {busy, done, error, new_service, error_code}, 0);
      chk("ar_cfg", {phy_write_read, phy_block_size, phy_timeout_en, phy_timeout}, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("ar_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
